decode_stage: RTL and testbench

Instruction decode stage of the five-stage MIPS datapath, directly downstream of the fetch stage. Consumes the fetched opcode, register specifiers and 16-bit immediate; drives the fetch stage's `signext`, `Jump`, `Branch` and `stop` inputs. Holds the 32-entry register file with writeback port, detects load-use hazards, and registers decoded operands and control into the ID/EX pipeline register.

---
 rtl/decode_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage of the five-stage MIPS pipeline.
// Decodes the fetched instruction, reads the register file (with writeback
// bypass), detects load-use hazards and fills the ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  // Fetched instruction fields
  input  logic             valid_in,
  input  logic [5:0]       Opcode,
  input  logic [4:0]       Reg1,
  input  logic [4:0]       Reg2,
  input  logic [15:0]      Immediate,
  // Hazard / squash inputs
  input  logic             flush,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  // Register file writeback port
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  // Combinational outputs back to fetch
  output logic [WIDTH-1:0] signext,
  output logic             Jump,
  output logic             Branch,
  output logic             stop,
  // ID/EX pipeline register
  output logic             id_valid,
  output logic [WIDTH-1:0] id_rs_data,
  output logic [WIDTH-1:0] id_rt_data,
  output logic [WIDTH-1:0] id_imm,
  output logic [4:0]       id_dest,
  output logic [5:0]       id_funct,
  output logic             id_regwrite,
  output logic             id_memread,
  output logic             id_memwrite,
  output logic             id_alusrc,
  output logic             id_memtoreg,
  output logic             id_illegal
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rf_q [NREGS];
  logic             wb_live;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;

  // A write to $0 is never live, so $0 can neither be stored nor bypassed.
  assign wb_live = wb_en && (wb_addr != 5'd0);

  // Register file storage: cleared on reset, one write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_live) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Combinational reads; a same-cycle writeback to the read address wins.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (Reg1 != 5'd0) begin
      rs_val = (wb_live && (wb_addr == Reg1)) ? wb_data : rf_q[Reg1];
    end
    if (Reg2 != 5'd0) begin
      rt_val = (wb_live && (wb_addr == Reg2)) ? wb_data : rf_q[Reg2];
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic       dec_supported;
  logic       dec_rt_src;
  logic       dec_jump;
  logic       dec_branch;
  logic       dec_regwrite;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_alusrc;
  logic       dec_memtoreg;
  logic [4:0] dec_dest;

  // Opcode to control-signal decode; unknown opcodes leave everything low.
  always_comb begin
    dec_supported = 1'b1;
    dec_rt_src    = 1'b0;
    dec_jump      = 1'b0;
    dec_branch    = 1'b0;
    dec_regwrite  = 1'b0;
    dec_memread   = 1'b0;
    dec_memwrite  = 1'b0;
    dec_alusrc    = 1'b0;
    dec_memtoreg  = 1'b0;
    dec_dest      = 5'd0;
    case (Opcode)
      OpRtype: begin
        dec_rt_src   = 1'b1;
        dec_regwrite = 1'b1;
        dec_dest     = Immediate[15:11];
      end
      OpLw: begin
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
        dec_dest     = Reg2;
      end
      OpSw: begin
        dec_rt_src   = 1'b1;
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
      end
      OpBeq: begin
        dec_rt_src = 1'b1;
        dec_branch = 1'b1;
      end
      OpAddi: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_dest     = Reg2;
      end
      OpJ: begin
        dec_jump = 1'b1;
      end
      default: begin
        dec_supported = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Combinational outputs to fetch
  // ---------------------------------------------------------------------------
  logic hit_rs;
  logic hit_rt;
  logic bubble;

  assign signext = {{(WIDTH - 16){Immediate[15]}}, Immediate};
  assign Jump    = dec_jump && valid_in && !flush;
  assign Branch  = dec_branch && valid_in && !flush;

  // Load-use: the load in EX targets a register this instruction reads.
  // rt only counts for instruction classes that actually source it.
  assign hit_rs = (ex_rt == Reg1);
  assign hit_rt = (ex_rt == Reg2) && dec_rt_src;
  assign stop   = valid_in && ex_memread && (ex_rt != 5'd0) && (hit_rs || hit_rt);

  // Flush, stall and empty slots all turn into a bubble in ID/EX.
  assign bubble = flush || stop || !valid_in;

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------------
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] rs_data_d, rs_data_q;
  logic [WIDTH-1:0] rt_data_d, rt_data_q;
  logic [WIDTH-1:0] imm_d, imm_q;
  logic [4:0]       dest_d, dest_q;
  logic [5:0]       funct_d, funct_q;
  logic             regwrite_d, regwrite_q;
  logic             memread_d, memread_q;
  logic             memwrite_d, memwrite_q;
  logic             alusrc_d, alusrc_q;
  logic             memtoreg_d, memtoreg_q;
  logic             illegal_d, illegal_q;

  // Next ID/EX contents: bubble, illegal marker, or the decoded instruction.
  // Illegal instructions carry no data so nothing stale leaks downstream.
  always_comb begin
    valid_d    = 1'b0;
    rs_data_d  = '0;
    rt_data_d  = '0;
    imm_d      = '0;
    dest_d     = 5'd0;
    funct_d    = 6'd0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    alusrc_d   = 1'b0;
    memtoreg_d = 1'b0;
    illegal_d  = 1'b0;
    if (!bubble) begin
      if (!dec_supported) begin
        illegal_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        rs_data_d  = rs_val;
        rt_data_d  = rt_val;
        imm_d      = signext;
        dest_d     = dec_dest;
        funct_d    = Immediate[5:0];
        regwrite_d = dec_regwrite;
        memread_d  = dec_memread;
        memwrite_d = dec_memwrite;
        alusrc_d   = dec_alusrc;
        memtoreg_d = dec_memtoreg;
      end
    end
  end

  // ID/EX state; asynchronous reset clears every field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      dest_q     <= 5'd0;
      funct_q    <= 6'd0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      dest_q     <= dest_d;
      funct_q    <= funct_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      memtoreg_q <= memtoreg_d;
      illegal_q  <= illegal_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_rs_data  = rs_data_q;
  assign id_rt_data  = rt_data_q;
  assign id_imm      = imm_q;
  assign id_dest     = dest_q;
  assign id_funct    = funct_q;
  assign id_regwrite = regwrite_q;
  assign id_memread  = memread_q;
  assign id_memwrite = memwrite_q;
  assign id_alusrc   = alusrc_q;
  assign id_memtoreg = memtoreg_q;
  assign id_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases followed by random traffic,
// checked against an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [5:0]  Opcode;
  logic [4:0]  Reg1, Reg2;
  logic [15:0] Immediate;
  logic        flush, ex_memread;
  logic [4:0]  ex_rt;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] signext;
  logic        Jump, Branch, stop;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_dest;
  logic [5:0]  id_funct;
  logic        id_regwrite, id_memread, id_memwrite, id_alusrc, id_memtoreg, id_illegal;

  decode_stage #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .Opcode(Opcode), .Reg1(Reg1), .Reg2(Reg2),
    .Immediate(Immediate), .flush(flush), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .signext(signext), .Jump(Jump),
    .Branch(Branch), .stop(stop), .id_valid(id_valid), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_dest(id_dest), .id_funct(id_funct),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [5:0]  funct;
    logic        rw, mr, mw, as, mt, ill;
  } idex_t;

  typedef struct {
    logic        vi;
    logic [5:0]  op;
    logic [4:0]  r1, r2;
    logic [15:0] imm;
    logic        fl, exm;
    logic [4:0]  ext;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } stim_t;

  idex_t       sb_q[$];
  logic [31:0] ref_rf [32];
  int          total = 0;
  int          bad   = 0;

  function automatic idex_t idex_now();
    return {id_valid, id_rs_data, id_rt_data, id_imm, id_dest, id_funct,
            id_regwrite, id_memread, id_memwrite, id_alusrc, id_memtoreg, id_illegal};
  endfunction

  function automatic stim_t mk(logic [5:0] op, logic [4:0] r1, logic [4:0] r2,
                               logic [15:0] imm);
    stim_t s;
    s.vi = 1'b1; s.op = op; s.r1 = r1; s.r2 = r2; s.imm = imm;
    s.fl = 1'b0; s.exm = 1'b0; s.ext = 5'd0; s.we = 1'b0; s.wa = 5'd0; s.wd = 32'd0;
    return s;
  endfunction

  // Architectural register read as seen by this instruction.
  function automatic logic [31:0] rd_reg(stim_t s, logic [4:0] a);
    if (a == 0) return 32'd0;
    if (s.we && s.wa == a) return s.wd;
    return ref_rf[a];
  endfunction

  // Reference: what the instruction means, and what decode must hand to EX.
  task automatic model(input stim_t s, output idex_t e, output logic [34:0] comb);
    logic known, rt_used, jmp, br, hazard;
    logic [31:0] sx;
    e = '0;
    sx = 32'(signed'(s.imm));
    known = 1'b1; rt_used = 1'b0; jmp = 1'b0; br = 1'b0;
    case (s.op)
      6'd0:  begin rt_used = 1; e.rw = 1; e.dest = s.imm[15:11]; end
      6'd35: begin e.rw = 1; e.mr = 1; e.as = 1; e.mt = 1; e.dest = s.r2; end
      6'd43: begin rt_used = 1; e.mw = 1; e.as = 1; end
      6'd4:  begin rt_used = 1; br = 1; end
      6'd8:  begin e.rw = 1; e.as = 1; e.dest = s.r2; end
      6'd2:  jmp = 1;
      default: known = 1'b0;
    endcase
    hazard = s.vi && s.exm && s.ext != 0 && (s.ext == s.r1 || (s.ext == s.r2 && rt_used));
    comb = {sx, jmp && s.vi && !s.fl, br && s.vi && !s.fl, hazard};
    if (!s.vi || s.fl || hazard) e = '0;
    else if (!known) begin e = '0; e.ill = 1'b1; end
    else begin
      e.v = 1'b1; e.rs = rd_reg(s, s.r1); e.rt = rd_reg(s, s.r2);
      e.imm = sx; e.funct = s.imm[5:0];
    end
  endtask

  // Drive one instruction at the falling edge, queue its ID/EX expectation,
  // and check the same-cycle outputs to fetch.
  task automatic issue(input stim_t s);
    idex_t e;
    logic [34:0] c;
    @(negedge clk);
    valid_in = s.vi; Opcode = s.op; Reg1 = s.r1; Reg2 = s.r2; Immediate = s.imm;
    flush = s.fl; ex_memread = s.exm; ex_rt = s.ext;
    wb_en = s.we; wb_addr = s.wa; wb_data = s.wd;
    model(s, e, c);
    sb_q.push_back(e);
    if (s.we && s.wa != 0) ref_rf[s.wa] = s.wd;
    #1;
    total++;
    if ({signext, Jump, Branch, stop} !== c) begin
      bad++;
      $display("FAIL comb op=%0d got sx=%h j=%b b=%b stop=%b want sx=%h j=%b b=%b stop=%b",
               s.op, signext, Jump, Branch, stop, c[34:3], c[2], c[1], c[0]);
    end
  endtask

  task automatic idle_inputs();
    valid_in = 0; Opcode = 0; Reg1 = 0; Reg2 = 0; Immediate = 0; flush = 0;
    ex_memread = 0; ex_rt = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic check_zero(input string name);
    total++;
    if (idex_now() !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", name, idex_now());
    end
  endtask

  // Monitor: ID/EX presents a new result after every rising edge.
  initial begin
    idex_t exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        total++;
        if (idex_now() !== exp_v) begin
          bad++;
          $display("FAIL idex got=%h want=%h", idex_now(), exp_v);
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [5:0] ops [6];
    ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4; ops[4] = 6'd8; ops[5] = 6'd2;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    idle_inputs();
    rst = 1'b1;
    #2;
    check_zero("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Writeback bypass into a same-cycle read, then a normal read.
    s = mk(6'd0, 5'd8, 5'd0, 16'h2025); s.we = 1; s.wa = 5'd8; s.wd = 32'hDEADBEEF;
    issue(s);
    issue(mk(6'd0, 5'd3, 5'd8, 16'h1822));
    // Writes to $0 are dropped, both bypassed and stored.
    s = mk(6'd0, 5'd0, 5'd0, 16'h0000); s.we = 1; s.wa = 5'd0; s.wd = 32'h1234;
    issue(s);
    issue(mk(6'd0, 5'd0, 5'd8, 16'h0000));
    // addi with a negative immediate.
    issue(mk(6'd8, 5'd8, 5'd7, 16'h8001));
    // Load-use on rs: one bubble, then issue once the load leaves EX.
    s = mk(6'd0, 5'd9, 5'd4, 16'h5020); s.exm = 1; s.ext = 5'd9;
    issue(s);
    s.exm = 0;
    issue(s);
    // addi does not read rt, so a load into rt is no hazard.
    s = mk(6'd8, 5'd3, 5'd9, 16'h0004); s.exm = 1; s.ext = 5'd9;
    issue(s);
    // A load into $0 never stalls.
    s = mk(6'd0, 5'd0, 5'd0, 16'h0000); s.exm = 1; s.ext = 5'd0;
    issue(s);
    // Flushed beq, then j.
    s = mk(6'd4, 5'd1, 5'd2, 16'hFFFC); s.fl = 1;
    issue(s);
    issue(mk(6'd4, 5'd1, 5'd2, 16'hFFFC));
    issue(mk(6'd2, 5'd0, 5'd0, 16'h0100));
    // Flush together with a stall.
    s = mk(6'd43, 5'd6, 5'd6, 16'h0010); s.fl = 1; s.exm = 1; s.ext = 5'd6;
    issue(s);
    // Unsupported opcode.
    issue(mk(6'b111111, 5'd1, 5'd2, 16'h1234));

    // Reset asserted mid-cycle while a stall is being presented.
    s = mk(6'd0, 5'd5, 5'd8, 16'h0000); s.we = 1; s.wa = 5'd5; s.wd = 32'h55AA55AA;
    issue(s);
    @(posedge clk);
    #2;
    valid_in = 1; Opcode = 6'd0; Reg1 = 5'd5; ex_memread = 1; ex_rt = 5'd5; wb_en = 0;
    rst = 1'b1;
    #1;
    check_zero("reset_mid_stall");
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    issue(mk(6'd0, 5'd5, 5'd8, 16'h2820));

    // Random traffic over a small register window to provoke hazards and bypasses.
    for (int n = 0; n < 400; n++) begin
      int k;
      k = $urandom_range(0, 6);
      s = mk((k == 6) ? 6'($urandom) : ops[k], 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 16'($urandom));
      s.vi  = ($urandom_range(0, 99) < 85);
      s.fl  = ($urandom_range(0, 99) < 12);
      s.exm = ($urandom_range(0, 99) < 30);
      s.ext = 5'($urandom_range(0, 7));
      s.we  = ($urandom_range(0, 1) == 1);
      s.wa  = 5'($urandom_range(0, 7));
      s.wd  = $urandom;
      issue(s);
    end

    @(negedge clk);
    idle_inputs();
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d pending want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
